// File: rtl/pong_ball_engine_if.sv
// Signal bundle between the Pong ball engine and its neighbours.
// The neighbours are the VGA timing generator, the paddle controllers, the score display and the colour mux.
interface pong_ball_engine_if #(
   parameter int SCORE_W = 2
);
   logic               enable;
   logic               frame_tick;
   logic               restart;
   logic               o_active;
   logic [9:0]         o_x;
   logic [8:0]         o_y;
   logic [8:0]         pad1_y;
   logic [8:0]         pad2_y;
   logic [1:0]         rnd;
   logic [9:0]         ball_x;
   logic [8:0]         ball_y;
   logic [SCORE_W-1:0] score1;
   logic [SCORE_W-1:0] score2;
   logic [1:0]         point_evt;
   logic               game_over;
   logic               pixel_on;

   modport master (
      output enable, frame_tick, restart, o_active, o_x, o_y, pad1_y, pad2_y, rnd,
      input  ball_x, ball_y, score1, score2, point_evt, game_over, pixel_on
   );

   modport slave (
      input  enable, frame_tick, restart, o_active, o_x, o_y, pad1_y, pad2_y, rnd,
      output ball_x, ball_y, score1, score2, point_evt, game_over, pixel_on
   );
endinterface

// File: rtl/pong_ball_engine.sv
// Pong ball engine: per-frame ball motion, wall/paddle/goal resolution,
// scoring and serve/play/over sequencing, plus the registered ball pixel layer.
module pong_ball_engine #(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int BALL         = 8,
   parameter int PAD_W        = 10,
   parameter int PAD_H        = 90,
   parameter int PAD1_X       = 10,
   parameter int PAD2_X       = 620,
   parameter int SPEED        = 2,
   parameter int WIN_SCORE    = 3,
   parameter int SERVE_FRAMES = 60,
   parameter int SCORE_W      = 2
) (
   input  logic              clk_in,
   input  logic              i_rst,
   pong_ball_engine_if.slave bus
);
   localparam int FC_W = $clog2(SERVE_FRAMES + 1);

   typedef logic signed [10:0] pos_t;
   typedef logic signed [3:0]  vel_t;

   localparam pos_t X_CTR    = pos_t'((H_ACTIVE - BALL) / 2);
   localparam pos_t Y_CTR    = pos_t'((V_ACTIVE - BALL) / 2);
   localparam pos_t Y_MAX    = pos_t'(V_ACTIVE - BALL);
   localparam pos_t H_S      = pos_t'(H_ACTIVE);
   localparam pos_t BALL_S   = pos_t'(BALL);
   localparam pos_t BALL_M1  = pos_t'(BALL - 1);
   localparam pos_t HALF     = pos_t'(BALL / 2);
   localparam pos_t SPD      = pos_t'(SPEED);
   localparam pos_t PH_M1    = pos_t'(PAD_H - 1);
   localparam pos_t ZONE1    = pos_t'(PAD_H / 3);
   localparam pos_t ZONE2    = pos_t'((2 * PAD_H) / 3);
   localparam pos_t P1_CLAMP = pos_t'(PAD1_X + PAD_W);
   localparam pos_t P2_CLAMP = pos_t'(PAD2_X - BALL);

   localparam vel_t DX_POS = vel_t'(SPEED);
   localparam vel_t DX_NEG = vel_t'(-SPEED);
   localparam vel_t DY_UP2 = vel_t'(-2);
   localparam vel_t DY_UP1 = vel_t'(-1);
   localparam vel_t DY_DN1 = vel_t'(1);
   localparam vel_t DY_DN2 = vel_t'(2);

   typedef enum logic [1:0] {S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

   state_t             state_reg, state_next;
   logic [FC_W-1:0]    frame_cnt_reg, frame_cnt_next;
   pos_t               ball_x_reg, ball_x_next;
   pos_t               ball_y_reg, ball_y_next;
   vel_t               dx_reg, dx_next;
   vel_t               dy_reg, dy_next;
   logic [SCORE_W-1:0] score1_reg, score1_next;
   logic [SCORE_W-1:0] score2_reg, score2_next;
   logic               p1_scored_reg, p1_scored_next;
   logic               pixel_on_reg, pixel_on_next;

   logic dx_neg, dx_pos;
   assign dx_neg = dx_reg[3];
   assign dx_pos = !dx_reg[3] && (dx_reg != '0);

   // Goals are judged on the current position, before any move this frame.
   logic goal_p1, goal_p2;
   assign goal_p2 = dx_neg && (ball_x_reg <= SPD);
   assign goal_p1 = dx_pos && (ball_x_reg + BALL_S + SPD >= H_S);

   pos_t ball_ctr_y;
   assign ball_ctr_y = ball_y_reg + HALF;

   logic [1:0] pad_hit;
   vel_t       pad_dy [2];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_pad
         localparam pos_t PX_L = pos_t'((gi == 0) ? PAD1_X : PAD2_X);
         localparam pos_t PX_R = pos_t'(((gi == 0) ? PAD1_X : PAD2_X) + PAD_W - 1);
         pos_t pad_top;
         pos_t pad_off;
         logic moving_in;

         assign pad_top   = $signed({2'b00, (gi == 0) ? bus.pad1_y : bus.pad2_y});
         // A paddle only sees the ball when it is travelling towards it.
         assign moving_in = (gi == 0) ? dx_neg : dx_pos;
         assign pad_hit[gi] = moving_in
                              && (ball_x_reg <= PX_R) && (ball_x_reg + BALL_M1 >= PX_L)
                              && (ball_y_reg <= pad_top + PH_M1) && (ball_y_reg + BALL_M1 >= pad_top);
         assign pad_off  = ball_ctr_y - pad_top;
         assign pad_dy[gi] = (pad_off < ZONE1)  ? DY_UP2 :
                             (pad_off >= ZONE2) ? DY_DN2 :
                             (dy_reg[3] ? DY_UP1 : DY_DN1);
      end
   endgenerate

   vel_t dy_hit, wall_dy;
   pos_t y_try, wall_y, x_step;

   always_comb begin
      dy_hit = dy_reg;
      if (pad_hit[0]) begin
         dy_hit = pad_dy[0];
      end else if (pad_hit[1]) begin
         dy_hit = pad_dy[1];
      end
      y_try   = ball_y_reg + $signed({{7{dy_hit[3]}}, dy_hit});
      wall_y  = y_try;
      wall_dy = dy_hit;
      if (y_try[10]) begin
         wall_y  = '0;
         wall_dy = -dy_hit;
      end else if (y_try > Y_MAX) begin
         wall_y  = Y_MAX;
         wall_dy = -dy_hit;
      end
   end

   assign x_step = ball_x_reg + $signed({{7{dx_reg[3]}}, dx_reg});

   logic [SCORE_W-1:0] score_inc;
   assign score_inc = (p1_scored_reg ? score1_reg : score2_reg) + SCORE_W'(1);

   always_comb begin
      state_next     = state_reg;
      frame_cnt_next = frame_cnt_reg;
      ball_x_next    = ball_x_reg;
      ball_y_next    = ball_y_reg;
      dx_next        = dx_reg;
      dy_next        = dy_reg;
      score1_next    = score1_reg;
      score2_next    = score2_reg;
      p1_scored_next = p1_scored_reg;
      // With enable low nothing advances, so ticks in that window are simply lost.
      if (bus.enable) begin
         case (state_reg)
            S_SERVE: begin
               ball_x_next = X_CTR;
               ball_y_next = Y_CTR;
               if (bus.frame_tick) begin
                  if (frame_cnt_reg == FC_W'(SERVE_FRAMES - 1)) begin
                     frame_cnt_next = '0;
                     state_next     = S_PLAY;
                     case (bus.rnd)
                        2'b00:   dy_next = DY_UP1;
                        2'b01:   dy_next = DY_DN1;
                        2'b10:   dy_next = DY_UP2;
                        default: dy_next = DY_DN2;
                     endcase
                  end else begin
                     frame_cnt_next = frame_cnt_reg + FC_W'(1);
                  end
               end
            end
            S_PLAY: begin
               if (bus.frame_tick) begin
                  if (goal_p2) begin
                     p1_scored_next = 1'b0;
                     state_next     = S_POINT;
                  end else if (goal_p1) begin
                     p1_scored_next = 1'b1;
                     state_next     = S_POINT;
                  end else begin
                     ball_y_next = wall_y;
                     dy_next     = wall_dy;
                     if (pad_hit[0]) begin
                        dx_next     = DX_POS;
                        ball_x_next = P1_CLAMP;
                     end else if (pad_hit[1]) begin
                        dx_next     = DX_NEG;
                        ball_x_next = P2_CLAMP;
                     end else begin
                        ball_x_next = x_step;
                     end
                  end
               end
            end
            S_POINT: begin
               if (p1_scored_reg) begin
                  score1_next = score_inc;
                  dx_next     = DX_NEG;
               end else begin
                  score2_next = score_inc;
                  dx_next     = DX_POS;
               end
               ball_x_next    = X_CTR;
               ball_y_next    = Y_CTR;
               frame_cnt_next = '0;
               state_next     = (score_inc == SCORE_W'(WIN_SCORE)) ? S_OVER : S_SERVE;
            end
            S_OVER: begin
               ball_x_next = X_CTR;
               ball_y_next = Y_CTR;
               if (bus.restart) begin
                  score1_next    = '0;
                  score2_next    = '0;
                  dx_next        = DX_POS;
                  dy_next        = '0;
                  frame_cnt_next = '0;
                  state_next     = S_SERVE;
               end
            end
            default: state_next = S_SERVE;
         endcase
      end
   end

   pos_t pix_x, pix_y;
   assign pix_x = $signed({1'b0, bus.o_x});
   assign pix_y = $signed({2'b00, bus.o_y});
   assign pixel_on_next = bus.enable && bus.o_active
                          && (pix_x >= ball_x_reg) && (pix_x <= ball_x_reg + BALL_M1)
                          && (pix_y >= ball_y_reg) && (pix_y <= ball_y_reg + BALL_M1);

   always_ff @(posedge clk_in) begin
      if (i_rst) begin
         state_reg     <= S_SERVE;
         frame_cnt_reg <= '0;
         ball_x_reg    <= X_CTR;
         ball_y_reg    <= Y_CTR;
         dx_reg        <= DX_POS;
         dy_reg        <= '0;
         score1_reg    <= '0;
         score2_reg    <= '0;
         p1_scored_reg <= 1'b0;
         pixel_on_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         frame_cnt_reg <= frame_cnt_next;
         ball_x_reg    <= ball_x_next;
         ball_y_reg    <= ball_y_next;
         dx_reg        <= dx_next;
         dy_reg        <= dy_next;
         score1_reg    <= score1_next;
         score2_reg    <= score2_next;
         p1_scored_reg <= p1_scored_next;
         pixel_on_reg  <= pixel_on_next;
      end
   end

   assign bus.ball_x    = ball_x_reg[9:0];
   assign bus.ball_y    = ball_y_reg[8:0];
   assign bus.score1    = score1_reg;
   assign bus.score2    = score2_reg;
   assign bus.point_evt = (state_reg == S_POINT) ? {p1_scored_reg, !p1_scored_reg} : 2'b00;
   assign bus.game_over = (state_reg == S_OVER);
   assign bus.pixel_on  = pixel_on_reg;
endmodule
